// File: rtl/eep_arb_pkg.sv
// Shared widths, default timeout and FSM encoding for the EEPROM read arbiter.
package eep_arb_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned LEN_W           = 17;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'd200000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/eep_req_slot.sv
// One requester's pending slot: captures a read request, flags zero-length
// requests and drops requests that arrive while the slot is busy.
module eep_req_slot
  import eep_arb_pkg::*;
(
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic              rden,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] addr,
  input  logic              serving,   // this requester is in ISSUE/BUSY
  input  logic              clear,     // slot handed to the reader this cycle
  output logic              pending,
  output logic [LEN_W-1:0]  slot_len,
  output logic [ADDR_W-1:0] slot_addr,
  output logic              err,
  output logic              ovf
);

  logic              pending_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              ovf_q;
  logic              zero_len;
  logic              drop;
  logic              take;

  // Zero length wins over overflow: it is an error, not a lost request.
  always_comb begin
    zero_len = rden && (length == '0);
    drop     = rden && !zero_len && (pending_q || serving);
    take     = rden && !zero_len && !pending_q && !serving;
  end

  // Slot capture plus single-cycle error/overflow pulses.
  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      pending_q <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      err_q <= zero_len;
      ovf_q <= drop;
      if (take) begin
        pending_q <= 1'b1;
        len_q     <= length;
        addr_q    <= addr;
      end else if (clear) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending   = pending_q;
  assign slot_len  = len_q;
  assign slot_addr = addr_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/eep_rd_arb.sv
// Round-robin arbiter sharing one EEPROM reader between two requesters.
// Optional BUSY watchdog enabled by defining EEP_RD_TIMEOUT_EN.
module eep_rd_arb
  import eep_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              glbl_rst,
  input  logic              req0_rden,
  input  logic [LEN_W-1:0]  req0_length,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_rden,
  input  logic [LEN_W-1:0]  req1_length,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req0_valid,
  output logic              req0_last,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_data,
  output logic              req1_valid,
  output logic              req1_last,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_data,
  output logic              eep_rden,
  output logic [LEN_W-1:0]  eep_length,
  output logic [ADDR_W-1:0] eep_addr,
  input  logic              eep_valid,
  input  logic              eep_last,
  input  logic [DATA_W-1:0] eep_data,
  output logic              busy,
  output logic              grant,
  output logic              req_ovf
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              ptr_q, ptr_d;      // preferred slot when both are pending
  logic              pend0, pend1, err0, err1, ovf0, ovf1;
  logic [LEN_W-1:0]  len0, len1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              in_service, serving0, serving1, clear0, clear1;
  logic              timeout_err;
  logic              route0, route1;
  logic              v0_q, l0_q, v1_q, l1_q, to_err0_q, to_err1_q;
  logic [DATA_W-1:0] d0_q, d1_q;

  assign in_service = (state_q == StIssue) || (state_q == StBusy);
  assign serving0   = in_service && !grant_q;
  assign serving1   = in_service && grant_q;
  assign clear0     = (state_q == StIssue) && !grant_q;
  assign clear1     = (state_q == StIssue) && grant_q;

  eep_req_slot u_slot0 (
    .sys_clk   (sys_clk),
    .glbl_rst  (glbl_rst),
    .rden      (req0_rden),
    .length    (req0_length),
    .addr      (req0_addr),
    .serving   (serving0),
    .clear     (clear0),
    .pending   (pend0),
    .slot_len  (len0),
    .slot_addr (addr0),
    .err       (err0),
    .ovf       (ovf0)
  );

  eep_req_slot u_slot1 (
    .sys_clk   (sys_clk),
    .glbl_rst  (glbl_rst),
    .rden      (req1_rden),
    .length    (req1_length),
    .addr      (req1_addr),
    .serving   (serving1),
    .clear     (clear1),
    .pending   (pend1),
    .slot_len  (len1),
    .slot_addr (addr1),
    .err       (err1),
    .ovf       (ovf1)
  );

`ifdef EEP_RD_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        to_hit;

  // A real last in the same cycle as the timeout takes precedence.
  assign to_hit      = (state_q == StBusy) && (to_cnt_q == TIMEOUT_CYC - 1);
  assign timeout_err = to_hit && !(eep_valid && eep_last);

  // Watchdog: cleared while issuing, counts every BUSY cycle.
  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      to_cnt_q <= '0;
    end else if (state_q == StIssue) begin
      to_cnt_q <= '0;
    end else if (state_q == StBusy) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

  // Next-state, grant and round-robin pointer selection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pend0 || pend1) begin
          grant_d = (pend0 && pend1) ? ptr_q : pend1;
          ptr_d   = !grant_d;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StBusy;
      StBusy: begin
        if ((eep_valid && eep_last) || timeout_err) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, grant and pointer registers.
  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Beats are only forwarded while BUSY, to the granted requester.
  assign route0 = (state_q == StBusy) && !grant_q && eep_valid;
  assign route1 = (state_q == StBusy) && grant_q && eep_valid;

  // Registered return path and timeout error pulses.
  always_ff @(posedge sys_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      v0_q      <= 1'b0;
      l0_q      <= 1'b0;
      d0_q      <= '0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      d1_q      <= '0;
      to_err0_q <= 1'b0;
      to_err1_q <= 1'b0;
    end else begin
      v0_q      <= route0;
      l0_q      <= route0 && eep_last;
      d0_q      <= route0 ? eep_data : '0;
      v1_q      <= route1;
      l1_q      <= route1 && eep_last;
      d1_q      <= route1 ? eep_data : '0;
      to_err0_q <= timeout_err && !grant_q;
      to_err1_q <= timeout_err && grant_q;
    end
  end

  assign req0_valid = v0_q;
  assign req0_last  = l0_q;
  assign req0_data  = d0_q;
  assign req0_err   = err0 || to_err0_q;
  assign req1_valid = v1_q;
  assign req1_last  = l1_q;
  assign req1_data  = d1_q;
  assign req1_err   = err1 || to_err1_q;
  assign req_ovf    = ovf0 || ovf1;
  assign busy       = (state_q != StIdle);
  assign grant      = grant_q;
  assign eep_rden   = (state_q == StIssue);
  assign eep_addr   = eep_rden ? (grant_q ? addr1 : addr0) : '0;
  assign eep_length = eep_rden ? (grant_q ? len1 : len0) : '0;

endmodule

// File: tb/tb_eep_rd_arb.sv
// Self-checking bench for eep_rd_arb: vector table of single transactions plus
// hand sequences for collision, round-robin, overflow, back-to-back, reset and timeout.
module tb_eep_rd_arb;

  logic        sys_clk = 1'b0;
  logic        glbl_rst;
  logic        req0_rden, req1_rden;
  logic [16:0] req0_length, req1_length;
  logic [15:0] req0_addr, req1_addr;
  logic        req0_valid, req0_last, req0_err, req1_valid, req1_last, req1_err;
  logic [7:0]  req0_data, req1_data;
  logic        eep_rden;
  logic [16:0] eep_length;
  logic [15:0] eep_addr;
  logic        eep_valid, eep_last;
  logic [7:0]  eep_data;
  logic        busy, grant, req_ovf;

  always #5 sys_clk = ~sys_clk;

  eep_rd_arb #(.TIMEOUT_CYC(100)) dut (
    .sys_clk     (sys_clk),
    .glbl_rst    (glbl_rst),
    .req0_rden   (req0_rden),
    .req0_length (req0_length),
    .req0_addr   (req0_addr),
    .req1_rden   (req1_rden),
    .req1_length (req1_length),
    .req1_addr   (req1_addr),
    .req0_valid  (req0_valid),
    .req0_last   (req0_last),
    .req0_err    (req0_err),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_last   (req1_last),
    .req1_err    (req1_err),
    .req1_data   (req1_data),
    .eep_rden    (eep_rden),
    .eep_length  (eep_length),
    .eep_addr    (eep_addr),
    .eep_valid   (eep_valid),
    .eep_last    (eep_last),
    .eep_data    (eep_data),
    .busy        (busy),
    .grant       (grant),
    .req_ovf     (req_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: counts output events on the falling edge.
  logic        mon_clr = 1'b0;
  int          n_v[2], n_l[2], last_idx[2], n_err[2], exp_d[2];
  int          n_ovf, n_rden, n_busy, data_err, zero_viol, stray_last;
  logic [15:0] rd_addr[4];
  logic [16:0] rd_len[4];
  logic        rd_grant[4];

  always @(negedge sys_clk) begin
    if (mon_clr) begin
      for (int r = 0; r < 2; r++) begin
        n_v[r] <= 0; n_l[r] <= 0; last_idx[r] <= 0; n_err[r] <= 0; exp_d[r] <= 0;
      end
      n_ovf <= 0; n_rden <= 0; n_busy <= 0; data_err <= 0; zero_viol <= 0; stray_last <= 0;
    end else begin
      if (req0_valid) begin
        if (req0_data != 8'(exp_d[0])) data_err <= data_err + 1;
        n_v[0] <= n_v[0] + 1;
        exp_d[0] <= req0_last ? 0 : exp_d[0] + 1;
        if (req0_last) begin
          n_l[0] <= n_l[0] + 1;
          last_idx[0] <= n_v[0] + 1;
        end
      end else if (req0_last) stray_last <= stray_last + 1;
      if (req1_valid) begin
        if (req1_data != 8'(exp_d[1])) data_err <= data_err + 1;
        n_v[1] <= n_v[1] + 1;
        exp_d[1] <= req1_last ? 0 : exp_d[1] + 1;
        if (req1_last) begin
          n_l[1] <= n_l[1] + 1;
          last_idx[1] <= n_v[1] + 1;
        end
      end else if (req1_last) stray_last <= stray_last + 1;
      if (req0_err) n_err[0] <= n_err[0] + 1;
      if (req1_err) n_err[1] <= n_err[1] + 1;
      if (req_ovf) n_ovf <= n_ovf + 1;
      if (busy) n_busy <= n_busy + 1;
      if (eep_rden) begin
        rd_addr[n_rden & 3]  <= eep_addr;
        rd_len[n_rden & 3]   <= eep_length;
        rd_grant[n_rden & 3] <= grant;
        n_rden <= n_rden + 1;
      end else if (eep_addr != '0 || eep_length != '0) begin
        zero_viol <= zero_viol + 1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge sys_clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    glbl_rst = 1'b1;
    req0_rden = 1'b0; req0_addr = '0; req0_length = '0;
    req1_rden = 1'b0; req1_addr = '0; req1_length = '0;
    eep_valid = 1'b0; eep_last = 1'b0; eep_data = '0;
    tick();
    tick();
    glbl_rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input int r, input logic [15:0] a, input logic [16:0] l);
    if (r == 0) begin
      req0_rden = 1'b1; req0_addr = a; req0_length = l;
    end else begin
      req1_rden = 1'b1; req1_addr = a; req1_length = l;
    end
    tick();
    req0_rden = 1'b0;
    req1_rden = 1'b0;
  endtask

  task automatic wait_rden(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (eep_rden) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Reader model: waits for the issue, then returns n beats with data = beat index.
  // Optionally re-pulses req0 in the cycle its routed last is visible.
  task automatic serve(input int n, input bit repulse0, input logic [15:0] ra,
                       input logic [16:0] rl);
    bit ok;
    wait_rden(ok);
    if (!ok) begin
      check("rden_wait_expired", 0, 1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      tick();
      eep_valid = 1'b1;
      eep_data  = 8'(i);
      eep_last  = (i == n - 1);
    end
    tick();
    eep_valid = 1'b0;
    eep_last  = 1'b0;
    if (repulse0) pulse(0, ra, rl);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && busy; i++) tick();
    check(name, busy, 0);
  endtask

  typedef struct {
    int          req;
    logic [15:0] addr;
    logic [16:0] len;
    int          beats;
    bit          issue;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k;
    int nv;
    bit ok;
    vecs[0] = '{0, 16'h0000, 17'h00384, 900, 1'b1};
    vecs[1] = '{1, 16'h1234, 17'h00005, 5, 1'b1};
    vecs[2] = '{0, 16'h00ff, 17'h00000, 0, 1'b0};
    vecs[3] = '{1, 16'h0abc, 17'h1ffff, 3, 1'b1};
    vecs[4] = '{1, 16'h7777, 17'h00000, 0, 1'b0};

    // Reset state
    do_reset();
    check("rst_ctl", {req0_valid, req0_last, req0_err, req1_valid, req1_last, req1_err,
                      eep_rden, busy, grant, req_ovf}, 0);
    check("rst_data", {req0_data, req1_data}, 0);
    check("rst_eep_addr", eep_addr, 0);
    check("rst_eep_len", eep_length, 0);

    // Vector table: one request each, from reset
    for (int i = 0; i < 5; i++) begin
      int r;
      int o;
      r = vecs[i].req;
      o = 1 - r;
      do_reset();
      clear_mon();
      pulse(r, vecs[i].addr, vecs[i].len);
      if (vecs[i].issue) serve(vecs[i].beats, 1'b0, '0, '0);
      else repeat (4) tick();
      wait_idle($sformatf("v%0d_idle", i));
      tick();
      check($sformatf("v%0d_rden_cnt", i), n_rden, vecs[i].issue ? 1 : 0);
      if (vecs[i].issue) begin
        check($sformatf("v%0d_rd_addr", i), rd_addr[0], vecs[i].addr);
        check($sformatf("v%0d_rd_len", i), rd_len[0], vecs[i].len);
        check($sformatf("v%0d_rd_grant", i), rd_grant[0], r);
      end
      check($sformatf("v%0d_valid_cnt", i), n_v[r], vecs[i].beats);
      check($sformatf("v%0d_last_idx", i), last_idx[r], vecs[i].beats);
      check($sformatf("v%0d_other_silent", i), n_v[o] + n_l[o] + n_err[o], 0);
      check($sformatf("v%0d_err_cnt", i), n_err[r], vecs[i].issue ? 0 : 1);
      check($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].issue ? vecs[i].beats + 2 : 0);
      check($sformatf("v%0d_data_err", i), data_err, 0);
      check($sformatf("v%0d_addr_len_zero", i), zero_viol, 0);
      check($sformatf("v%0d_ovf", i), n_ovf, 0);
    end

    // Collision right after reset: req0 first, req1 after the gap
    do_reset();
    clear_mon();
    req1_rden = 1'b1; req1_addr = 16'h0400; req1_length = 17'h10;
    pulse(0, 16'h0000, 17'h384);
    serve(900, 1'b0, '0, '0);
    serve(16, 1'b0, '0, '0);
    wait_idle("col_idle");
    tick();
    check("col_rden_cnt", n_rden, 2);
    check("col_first_grant", rd_grant[0], 0);
    check("col_first_len", rd_len[0], 17'h384);
    check("col_second_grant", rd_grant[1], 1);
    check("col_second_addr", rd_addr[1], 16'h0400);
    check("col_second_len", rd_len[1], 17'h10);
    check("col_v0_cnt", n_v[0], 900);
    check("col_v1_cnt", n_v[1], 16);
    check("col_stray_last", stray_last, 0);

    // Round-robin: after serving slot 0, a collision goes to slot 1 first
    do_reset();
    clear_mon();
    pulse(0, 16'h0011, 17'h3);
    serve(3, 1'b0, '0, '0);
    wait_idle("rr_idle0");
    req1_rden = 1'b1; req1_addr = 16'h0022; req1_length = 17'h2;
    pulse(0, 16'h0033, 17'h2);
    serve(2, 1'b0, '0, '0);
    serve(2, 1'b0, '0, '0);
    wait_idle("rr_idle1");
    tick();
    check("rr_second_grant", rd_grant[1], 1);
    check("rr_second_addr", rd_addr[1], 16'h0022);
    check("rr_third_grant", rd_grant[2], 0);
    check("rr_third_addr", rd_addr[2], 16'h0033);

    // Overflow: req1 pulsed twice while req0 is served
    do_reset();
    clear_mon();
    pulse(0, 16'h0010, 17'd20);
    fork
      serve(20, 1'b0, '0, '0);
      begin
        repeat (5) tick();
        pulse(1, 16'h0400, 17'h8);
        tick();
        pulse(1, 16'h0500, 17'h9);
      end
    join
    check("ovf_once", n_ovf, 1);
    serve(8, 1'b0, '0, '0);
    wait_idle("ovf_idle");
    tick();
    check("ovf_rden_cnt", n_rden, 2);
    check("ovf_req1_addr", rd_addr[1], 16'h0400);
    check("ovf_req1_beats", n_v[1], 8);
    // A requester pulsing during its own service is also dropped
    pulse(1, 16'h0600, 17'h4);
    fork
      serve(6, 1'b0, '0, '0);
      begin
        repeat (4) tick();
        pulse(1, 16'h0700, 17'h4);
      end
    join
    repeat (6) tick();
    check("ovf_self_cnt", n_ovf, 2);
    check("ovf_self_rden", n_rden, 3);
    check("ovf_self_idle", busy, 0);

    // New pulse accepted in the same cycle as the routed last
    do_reset();
    clear_mon();
    pulse(0, 16'h0020, 17'h4);
    serve(4, 1'b1, 16'h0030, 17'h6);
    serve(6, 1'b0, '0, '0);
    wait_idle("b2b_idle");
    tick();
    check("b2b_rden_cnt", n_rden, 2);
    check("b2b_addr", rd_addr[1], 16'h0030);
    check("b2b_len", rd_len[1], 17'h6);
    check("b2b_ovf", n_ovf, 0);
    check("b2b_beats", n_v[0], 10);
    check("b2b_lasts", n_l[0], 2);

    // Reset asserted on beat 10; later beats must not be routed
    do_reset();
    clear_mon();
    pulse(0, 16'h0000, 17'h384);
    wait_rden(ok);
    check("mid_rden_seen", ok, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      eep_valid = 1'b1;
      eep_data  = 8'(i);
      if (i == 9) glbl_rst = 1'b1;
    end
    #1;
    check("mid_rst_ctl", {req0_valid, req0_last, req0_err, req1_valid, req1_last, req1_err,
                          eep_rden, busy, grant, req_ovf}, 0);
    check("mid_rst_data", {req0_data, req1_data}, 0);
    check("mid_rst_eep", {eep_addr, eep_length}, 0);
    tick();
    tick();
    glbl_rst = 1'b0;
    nv = n_v[0];
    for (int i = 0; i < 5; i++) begin
      eep_data = 8'(10 + i);
      eep_last = (i == 4);
      tick();
    end
    eep_valid = 1'b0;
    eep_last  = 1'b0;
    tick();
    check("mid_no_stale_valid", n_v[0], nv);
    check("mid_no_stale_last", n_l[0], 0);
    check("mid_rden_cnt", n_rden, 1);
    check("mid_busy", busy, 0);

`ifdef EEP_RD_TIMEOUT_EN
    // Watchdog: no last, error 100 cycles after entering BUSY
    do_reset();
    clear_mon();
    pulse(0, 16'h0050, 17'h10);
    wait_rden(ok);
    check("to_rden_seen", ok, 1);
    k = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (req0_err) begin
        k = i;
        break;
      end
    end
    check("to_err_latency", k, 101);
    tick();
    check("to_back_idle", busy, 0);
    pulse(1, 16'h0060, 17'h4);
    serve(4, 1'b0, '0, '0);
    wait_idle("to_req1_idle");
    tick();
    check("to_req1_beats", n_v[1], 4);
    check("to_req1_last", n_l[1], 1);
    check("to_err0_cnt", n_err[0], 1);
    check("to_err1_cnt", n_err[1], 0);
`else
    // Without the watchdog the arbiter waits in BUSY indefinitely
    do_reset();
    clear_mon();
    pulse(0, 16'h0050, 17'h10);
    k = 0;
    repeat (300) tick();
    check("nto_still_busy", busy, 1);
    check("nto_no_err", n_err[0], 0);
    do_reset();
    check("nto_reset_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eep_rd_arb.md
EEP_RD_ARB -- requirements
Module: eep_rd_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd200000, the maximum number of cycles in BUSY without eep_last.
REQ-002 SHALL have ports sys_clk (in, 1, sole clock) and glbl_rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-003 SHALL have ports reqN_rden (in, 1, request pulse), reqN_length (in, 17, byte count) and reqN_addr (in, 16, start address), for N = 0 and 1.
REQ-004 SHALL have ports reqN_valid, reqN_last and reqN_err (out, 1 each) and reqN_data (out, 8), for N = 0 and 1.
REQ-005 SHALL have ports eep_rden (out, 1), eep_length (out, 17) and eep_addr (out, 16); these drive the shared EEPROM reader.
REQ-006 SHALL have ports eep_valid (in, 1), eep_last (in, 1) and eep_data (in, 8); these are the reader's return stream.
REQ-007 SHALL have ports busy (out, 1, transaction in progress), grant (out, 1, index of the served requester) and req_ovf (out, 1, dropped-request pulse).

Function
REQ-008 SHALL capture reqN_rden=1 into pending slot N together with its addr/length, visible to the arbiter on the following cycle.
REQ-009 SHALL drop reqN_rden when slot N is pending or requester N is being served, and SHALL pulse req_ovf for 1 cycle.
REQ-010 SHALL reject reqN_length==0: pulse reqN_err for 1 cycle, capture nothing, issue no transaction.
REQ-011 SHALL implement states IDLE, ISSUE, BUSY, GAP.
  - IDLE->ISSUE when any slot is pending.
  - ISSUE->BUSY always.
  - BUSY->GAP on eep_valid&eep_last, or on timeout.
  - GAP->IDLE always.
REQ-012 SHALL, in IDLE with both slots pending, grant the slot that was not served last; the round-robin pointer resets to slot 0 first.
REQ-013 SHALL, in ISSUE, drive eep_rden=1 for exactly 1 cycle with the granted slot's addr/length, then clear that slot.
REQ-014 SHALL route eep_valid/eep_data/eep_last to the granted requester only, registered with 1-cycle latency; all other reqN_valid/reqN_last SHALL be 0.
REQ-015 SHALL ignore eep_valid/eep_last in IDLE and ISSUE (no routing).
REQ-016 SHALL accept a new pulse from requester N in the same cycle as its own routed last.
REQ-017 SHALL capture simultaneous pulses from both requesters in the same cycle; both are served, in round-robin order.
REQ-018 SHALL drive busy=1 in ISSUE, BUSY and GAP, and busy=0 in IDLE.
REQ-019 SHALL give eep_length and eep_addr the value 0 whenever eep_rden=0.

Reset
REQ-020 SHALL, on glbl_rst, clear all outputs to 0, clear both pending slots, clear the timeout counter, set the pointer to slot 0 and enter IDLE, including mid-transaction.
REQ-021 SHALL, after reset release, not route stale eep_valid beats; the first transaction starts from IDLE.

Configuration
REQ-022 SHALL, with macro EEP_RD_TIMEOUT_EN defined, count cycles in BUSY and, when the count reaches TIMEOUT_CYC without last, pulse reqN_err of the granted requester for 1 cycle and go to GAP; the counter clears on entering BUSY.
REQ-023 SHALL, without EEP_RD_TIMEOUT_EN, contain no counter and wait in BUSY indefinitely; reqN_err then comes only from REQ-010.

Structure
REQ-024 SHALL place the state encodings, the widths ADDR_W=16, LEN_W=17 and DATA_W=8, and the default TIMEOUT_CYC in shared package eep_arb_pkg.
REQ-025 SHALL implement the per-requester capture/overflow/zero-length logic as sub-module eep_req_slot, instanced twice.

Verification
REQ-026 Single request: req0 pulse with addr=0x0000, len=0x384; bench returns 900 beats with last on beat 900 -> one eep_rden pulse with addr 0x0000 and len 0x384; req0_valid count = 900; req0_last on the final beat; req1 outputs silent.
REQ-027 Collision: req0 (0x0000/0x384) and req1 (0x0400/0x10) pulsed in the same cycle after reset -> req0 served first; req1 issued after GAP with addr 0x0400 and len 0x10.
REQ-028 Overflow: req1 pulsed twice while req0 is being served -> second pulse dropped; req_ovf pulses once; req1 served once.
REQ-029 Zero length: req0 pulse with len=0 -> req0_err pulses 1 cycle; eep_rden stays 0; busy stays 0.
REQ-030 Timeout (EEP_RD_TIMEOUT_EN defined, TIMEOUT_CYC=100): eep_last withheld -> req0_err pulses 100 cycles after entering BUSY; FSM returns to IDLE; a following req1 request completes normally.
REQ-031 Reset mid-BUSY: glbl_rst asserted on beat 10 -> all outputs 0 and busy=0; late eep_valid beats not routed.
